// File: rtl/spi_minion_frontend.sv
// SPI mode-0 minion front end: synchronises cs/sclk/mosi into i_clk, deserialises one
// PKT_W-bit frame per chip-select window onto a val/rdy stream and shifts one message out on miso.
module spi_minion_frontend #(
    parameter int unsigned PKT_W    = 20,
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cs,
    input  logic             i_sclk,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic [PKT_W-1:0] o_recv_msg,
    output logic             o_recv_val,
    input  logic             i_recv_rdy,
    input  logic [PKT_W-1:0] i_send_msg,
    input  logic             i_send_val,
    output logic             o_send_rdy,
    output logic             o_minion_parity,
    output logic             o_overrun,
    output logic             o_frame_err
);

    localparam int unsigned CNT_W = $clog2(PKT_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PKT_W + 1);

    typedef enum logic {StIdle, StShift} state_t;

    logic [SYNC_LEN-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
    logic                r_cs_prev, r_sclk_prev;
    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [PKT_W-1:0]    r_rx_shift, w_rx_shift_nxt;
    logic [PKT_W-1:0]    r_tx_shift, w_tx_shift_nxt;
    logic                r_miso, w_miso_nxt;
    logic [PKT_W-1:0]    r_recv_msg, w_recv_msg_nxt;
    logic                r_recv_val, w_recv_val_nxt;
    logic                r_parity, w_parity_nxt;
    logic                r_send_rdy, w_send_rdy_nxt;
    logic                r_overrun, w_overrun_nxt;
    logic                r_frame_err, w_frame_err_nxt;

    logic             w_cs, w_sclk, w_mosi;
    logic             w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
    logic             w_out_free;
    logic [PKT_W-1:0] w_tx_load;

    assign w_cs        = r_cs_sync[SYNC_LEN-1];
    assign w_sclk      = r_sclk_sync[SYNC_LEN-1];
    assign w_mosi      = r_mosi_sync[SYNC_LEN-1];
    assign w_cs_fall   = r_cs_prev & ~w_cs;
    assign w_cs_rise   = ~r_cs_prev & w_cs;
    assign w_sclk_rise = ~r_sclk_prev & w_sclk;
    assign w_sclk_fall = r_sclk_prev & ~w_sclk;
    assign w_out_free  = ~r_recv_val | i_recv_rdy;
    assign w_tx_load   = i_send_val ? i_send_msg : '0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_LEN-2:0], i_cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_LEN-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_LEN-2:0], i_mosi};
            r_cs_prev   <= w_cs;
            r_sclk_prev <= w_sclk;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_miso      <= 1'b0;
            r_recv_msg  <= '0;
            r_recv_val  <= 1'b0;
            r_parity    <= 1'b0;
            r_send_rdy  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_rx_shift  <= w_rx_shift_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
            r_miso      <= w_miso_nxt;
            r_recv_msg  <= w_recv_msg_nxt;
            r_recv_val  <= w_recv_val_nxt;
            r_parity    <= w_parity_nxt;
            r_send_rdy  <= w_send_rdy_nxt;
            r_overrun   <= w_overrun_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_rx_shift_nxt  = r_rx_shift;
        w_tx_shift_nxt  = r_tx_shift;
        w_miso_nxt      = r_miso;
        w_recv_msg_nxt  = r_recv_msg;
        w_recv_val_nxt  = r_recv_val;
        w_parity_nxt    = r_parity;
        w_send_rdy_nxt  = 1'b0;
        w_overrun_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;

        // A frame loading in the same cycle overrides this drain below.
        if (r_recv_val && i_recv_rdy) begin
            w_recv_val_nxt = 1'b0;
        end

        unique case (r_state)
            StIdle: begin
                w_miso_nxt = 1'b0;
                if (w_cs_fall) begin
                    w_state_nxt    = StShift;
                    w_bit_cnt_nxt  = '0;
                    w_tx_shift_nxt = w_tx_load;
                    w_miso_nxt     = w_tx_load[PKT_W-1];
                    w_send_rdy_nxt = i_send_val;
                end
            end
            StShift: begin
                if (w_cs_rise) begin
                    w_state_nxt = StIdle;
                    w_miso_nxt  = 1'b0;
                    if (r_bit_cnt == CNT_FULL) begin
                        if (w_out_free) begin
                            w_recv_msg_nxt = r_rx_shift;
                            w_parity_nxt   = ^r_rx_shift;
                            w_recv_val_nxt = 1'b1;
                        end else begin
                            w_overrun_nxt = 1'b1;
                        end
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end else begin
                    if (w_sclk_rise) begin
                        w_rx_shift_nxt = {r_rx_shift[PKT_W-2:0], w_mosi};
                        // Saturate so an over-long frame can never alias back to PKT_W.
                        if (r_bit_cnt != CNT_MAX) begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                    if (w_sclk_fall && (r_bit_cnt != '0)) begin
                        w_tx_shift_nxt = {r_tx_shift[PKT_W-2:0], 1'b0};
                        w_miso_nxt     = r_tx_shift[PKT_W-2];
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign o_miso          = r_miso;
    assign o_recv_msg      = r_recv_msg;
    assign o_recv_val      = r_recv_val;
    assign o_minion_parity = r_parity;
    assign o_send_rdy      = r_send_rdy;
    assign o_overrun       = r_overrun;
    assign o_frame_err     = r_frame_err;

endmodule
